// File: rtl/shift_unit_arbiter.sv
// Two-requester round-robin arbiter in front of one shared 64-bit right barrel shifter.
// Left shifts reuse the right shifter through bit reversal. Define SHIFT_ARB_WORD_EN to enable 32-bit W-form ops.
module shift_unit_arbiter #(
    parameter int XLEN     = 64,
    parameter int RST_PRIO = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_data,
    input  logic [5:0]      req0_shamt,
    input  logic            req0_left,
    input  logic            req0_arith,
    input  logic            req0_word,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_data,
    input  logic [5:0]      req1_shamt,
    input  logic            req1_left,
    input  logic            req1_arith,
    input  logic            req1_word,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result,
    output logic            busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic            prio_r;
    logic            grant_r;
    logic            grant_s;
    logic            xfer_s;
    logic            rsp_xfer_s;
    logic            req0_ready_s;
    logic            req1_ready_s;
    logic [XLEN-1:0] data_r;
    logic [5:0]      shamt_r;
    logic            left_r;
    logic            arith_r;
    logic            rsp0_valid_r;
    logic            rsp1_valid_r;
    logic [XLEN-1:0] result_r;
    logic [XLEN-1:0] src_s;
    logic [5:0]      amt_s;
    logic [XLEN-1:0] raw_s;
    logic [XLEN-1:0] shift_out_s;
`ifdef SHIFT_ARB_WORD_EN
    logic            word_r;
`else
    logic            unused_word_s;
    assign unused_word_s = req0_word ^ req1_word;
`endif

    function automatic logic [XLEN-1:0] rev_bits(input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        r = {XLEN{1'b0}};
        for (int i = 0; i < XLEN; i++) begin
            r[i] = d[XLEN-1-i];
        end
        return r;
    endfunction

    function automatic logic [XLEN-1:0] shift_right(input logic [XLEN-1:0] d,
                                                    input logic [5:0]      amt,
                                                    input logic            arith);
        logic [XLEN-1:0] fill;
        if (arith && d[XLEN-1]) begin
            fill = ~({XLEN{1'b1}} >> amt);
        end else begin
            fill = {XLEN{1'b0}};
        end
        return (d >> amt) | fill;
    endfunction

    // Next-state logic, grant selection and combinational request ready.
    always_comb begin
        state_next_s = state_r;
        grant_s      = prio_r;
        xfer_s       = 1'b0;
        rsp_xfer_s   = 1'b0;
        req0_ready_s = 1'b0;
        req1_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant_s = prio_r;
                end else if (req1_valid) begin
                    grant_s = 1'b1;
                end else begin
                    grant_s = 1'b0;
                end
                // Ready stays low while reset is asserted so nothing transfers.
                if (rst_n && (req0_valid || req1_valid)) begin
                    req0_ready_s = ~grant_s;
                    req1_ready_s = grant_s;
                    xfer_s       = 1'b1;
                    state_next_s = ST_EXEC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_next_s = ST_RESP;
            end
            ST_RESP: begin
                rsp_xfer_s = grant_r ? rsp1_ready : rsp0_ready;
                if (rsp_xfer_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_RESP;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture and round-robin priority update on request transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_r  <= (RST_PRIO != 0);
            grant_r <= 1'b0;
            data_r  <= {XLEN{1'b0}};
            shamt_r <= 6'd0;
            left_r  <= 1'b0;
            arith_r <= 1'b0;
`ifdef SHIFT_ARB_WORD_EN
            word_r  <= 1'b0;
`endif
        end else if (xfer_s) begin
            prio_r  <= ~grant_s;
            grant_r <= grant_s;
            data_r  <= grant_s ? req1_data  : req0_data;
            shamt_r <= grant_s ? req1_shamt : req0_shamt;
            left_r  <= grant_s ? req1_left  : req0_left;
            arith_r <= grant_s ? req1_arith : req0_arith;
`ifdef SHIFT_ARB_WORD_EN
            word_r  <= grant_s ? req1_word  : req0_word;
`endif
        end
    end

    // Shift datapath: operand shaping, shared right shifter, result shaping.
    always_comb begin
        src_s = data_r;
        amt_s = shamt_r;
`ifdef SHIFT_ARB_WORD_EN
        if (word_r) begin
            amt_s = {1'b0, shamt_r[4:0]};
            src_s = {{(XLEN-32){arith_r & ~left_r & data_r[31]}}, data_r[31:0]};
        end else begin
            amt_s = shamt_r;
            src_s = data_r;
        end
`endif
        if (left_r) begin
            raw_s = rev_bits(shift_right(rev_bits(src_s), amt_s, 1'b0));
        end else begin
            raw_s = shift_right(src_s, amt_s, arith_r);
        end
        shift_out_s = raw_s;
`ifdef SHIFT_ARB_WORD_EN
        if (word_r) begin
            shift_out_s = {{(XLEN-32){raw_s[31]}}, raw_s[31:0]};
        end else begin
            shift_out_s = raw_s;
        end
`endif
    end

    // Result register and per-requester response valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_r     <= {XLEN{1'b0}};
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end else if (state_r == ST_EXEC) begin
            result_r     <= shift_out_s;
            rsp0_valid_r <= ~grant_r;
            rsp1_valid_r <= grant_r;
        end else if (rsp_xfer_s) begin
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
        end
    end

    assign req0_ready  = req0_ready_s;
    assign req1_ready  = req1_ready_s;
    assign rsp0_valid  = rsp0_valid_r;
    assign rsp1_valid  = rsp1_valid_r;
    assign rsp0_result = result_r;
    assign rsp1_result = result_r;
    assign busy        = (state_r != ST_IDLE);

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed plus randomized bench for shift_unit_arbiter with a behavioural shift/arbitration model.
module tb_shift_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_data = 64'd0, req1_data = 64'd0;
    logic [5:0]  req0_shamt = 6'd0, req1_shamt = 6'd0;
    logic        req0_left = 1'b0, req1_left = 1'b0;
    logic        req0_arith = 1'b0, req1_arith = 1'b0;
    logic        req0_word = 1'b0, req1_word = 1'b0;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [63:0] rsp0_result, rsp1_result;
    logic        busy;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.XLEN(64), .RST_PRIO(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_shamt(req0_shamt), .req0_left(req0_left), .req0_arith(req0_arith),
        .req0_word(req0_word), .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_shamt(req1_shamt), .req1_left(req1_left), .req1_arith(req1_arith),
        .req1_word(req1_word), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result),
        .busy(busy)
    );

    int          total = 0;
    int          bad = 0;
    bit          prio_m = 1'b0;
    bit          vv[2];
    logic [63:0] od[2];
    logic [5:0]  os[2];
    bit          ol[2], oa[2], ow[2];

    function automatic logic [63:0] ref_shift(input logic [63:0] d, input logic [5:0] s,
                                              input bit l, input bit a, input bit w);
        logic signed [63:0] sd;
        logic signed [31:0] sw;
        logic [31:0]        r32;
`ifdef SHIFT_ARB_WORD_EN
        if (w) begin
            sw = d[31:0];
            if (l)      r32 = d[31:0] << s[4:0];
            else if (a) r32 = sw >>> s[4:0];
            else        r32 = d[31:0] >> s[4:0];
            return {{32{r32[31]}}, r32};
        end
`else
        sw  = {31'd0, w};
        r32 = sw;
`endif
        sd = d;
        if (l) return d << s;
        if (a) return sd >>> s;
        return d >> s;
    endfunction

    function automatic int exp_grant();
        if (vv[0] && vv[1]) return int'(prio_m);
        return vv[1] ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        req0_valid = vv[0]; req0_data = od[0]; req0_shamt = os[0];
        req0_left  = ol[0]; req0_arith = oa[0]; req0_word = ow[0];
        req1_valid = vv[1]; req1_data = od[1]; req1_shamt = os[1];
        req1_left  = ol[1]; req1_arith = oa[1]; req1_word = ow[1];
    endtask

    task automatic set_op(input int id, input logic [63:0] d, input logic [5:0] s,
                          input bit l, input bit a, input bit w);
        od[id] = d; os[id] = s; ol[id] = l; oa[id] = a; ow[id] = w; vv[id] = 1'b1;
    endtask

    // Run one grant/execute/response cycle for requester id with a stalled response.
    task automatic serve(input int id, input logic [63:0] exp_res, input int stall);
        drive();
        #1;
        chk("ready_grant", (id == 0) ? req0_ready : req1_ready, 64'd1);
        chk("ready_other", (id == 0) ? req1_ready : req0_ready, 64'd0);
        tick();
        prio_m = (id == 0);
        vv[id] = 1'b0;
        od[id] = ~od[id]; os[id] = ~os[id]; ol[id] = ~ol[id]; oa[id] = ~oa[id];
        drive();
        #1;
        chk("exec_busy", busy, 64'd1);
        chk("exec_rsp", {rsp1_valid, rsp0_valid}, 64'd0);
        chk("exec_ready", {req1_ready, req0_ready}, 64'd0);
        tick();
        chk("resp_valid", {rsp1_valid, rsp0_valid}, (id == 0) ? 64'd1 : 64'd2);
        chk("resp_result", (id == 0) ? rsp0_result : rsp1_result, exp_res);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk("stall_valid", {rsp1_valid, rsp0_valid}, (id == 0) ? 64'd1 : 64'd2);
            chk("stall_result", (id == 0) ? rsp0_result : rsp1_result, exp_res);
            chk("stall_ready", {req1_ready, req0_ready}, 64'd0);
        end
        if (id == 0) rsp0_ready = 1'b1;
        else         rsp1_ready = 1'b1;
        tick();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        #1;
        chk("idle_busy", busy, 64'd0);
        chk("idle_rsp", {rsp1_valid, rsp0_valid}, 64'd0);
    endtask

    initial begin
        int g;
        logic [63:0] exp6;
        vv[0] = 1'b0; vv[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            od[i] = 64'd0; os[i] = 6'd0; ol[i] = 1'b0; oa[i] = 1'b0; ow[i] = 1'b0;
        end

        // Reset state, with a request pending that must not be accepted
        rst_n = 1'b0;
        set_op(0, 64'h1234, 6'd1, 1'b0, 1'b0, 1'b0);
        drive();
        tick();
        tick();
        chk("rst_ready0", req0_ready, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_rsp", {rsp1_valid, rsp0_valid}, 64'd0);
        chk("rst_result0", rsp0_result, 64'd0);
        chk("rst_result1", rsp1_result, 64'd0);
        vv[0] = 1'b0;
        drive();
        rst_n = 1'b1;
        tick();

        // Simultaneous pair, alternation, then a second pair
        set_op(0, 64'h00FF, 6'd4, 1'b1, 1'b0, 1'b0);
        set_op(1, 64'hF0F0, 6'd8, 1'b0, 1'b0, 1'b0);
        serve(0, 64'h0FF0, 0);
        serve(1, 64'h00F0, 0);
        set_op(0, 64'h8, 6'd3, 1'b0, 1'b0, 1'b0);
        set_op(1, 64'h8, 6'd1, 1'b0, 1'b0, 1'b0);
        serve(0, 64'h1, 0);
        serve(1, 64'h4, 0);

        // Directed shift cases and a stalled response
        set_op(0, 64'hF000_0000_0000_0001, 6'd4, 1'b0, 1'b1, 1'b0);
        serve(0, 64'hFF00_0000_0000_0000, 0);
        set_op(1, 64'h1, 6'd63, 1'b1, 1'b0, 1'b0);
        serve(1, 64'h8000_0000_0000_0000, 0);
        set_op(0, 64'h8000_0000_0000_0000, 6'd63, 1'b0, 1'b1, 1'b0);
        serve(0, 64'hFFFF_FFFF_FFFF_FFFF, 5);
        set_op(1, 64'hDEAD_BEEF_0123_4567, 6'd0, 1'b0, 1'b1, 1'b0);
        serve(1, 64'hDEAD_BEEF_0123_4567, 0);
`ifdef SHIFT_ARB_WORD_EN
        exp6 = 64'hFFFF_FFFF_C000_0000;
`else
        exp6 = 64'h0000_0000_4000_0000;
`endif
        set_op(0, 64'h0000_0000_8000_0000, 6'd1, 1'b0, 1'b1, 1'b1);
        serve(0, exp6, 1);

        // Reset during EXEC drops the op and restores priority
        set_op(0, 64'h5, 6'd1, 1'b0, 1'b0, 1'b0);
        drive();
        #1;
        tick();
        vv[0] = 1'b0;
        drive();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_busy", busy, 64'd0);
        chk("mid_rst_rsp", {rsp1_valid, rsp0_valid}, 64'd0);
        rst_n = 1'b1;
        prio_m = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale_rsp", {rsp1_valid, rsp0_valid, busy}, 64'd0);
        end
        set_op(0, 64'h3, 6'd1, 1'b1, 1'b0, 1'b0);
        set_op(1, 64'h3, 6'd1, 1'b0, 1'b0, 1'b0);
        serve(0, 64'h6, 0);
        serve(1, 64'h1, 0);

        // Randomized traffic against the reference model
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!vv[i] && ($urandom_range(0, 2) != 0)) begin
                    set_op(i, {$urandom, $urandom}, 6'($urandom_range(0, 63)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)));
                end
            end
            if (!vv[0] && !vv[1]) begin
                set_op(1, {$urandom, $urandom}, 6'd63, 1'b0, 1'b1, 1'b0);
            end
            g = exp_grant();
            serve(g, ref_shift(od[g], os[g], ol[g], oa[g], ow[g]), $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
